// File: rtl/pwm_timer_n.sv
// pwm_timer_n: parametrised PWM timer with prescaler, edge/center-aligned counting,
// per-channel polarity and configuration shadowed until each period end.
module pwm_timer_n #(
    parameter int W  = 16,
    parameter int CH = 4,
    parameter int PW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic [PW-1:0] psc,
    input  logic [W-1:0]  arr,
    input  logic [CH*W-1:0] cmp,
    input  logic [CH-1:0] pol,
    input  logic          center,
    output logic [W-1:0]  cnt,
    output logic          dir,
    output logic          upd,
    output logic [CH-1:0] cmp_out
);
    logic [PW-1:0]   pcnt;
    logic [W-1:0]    sh_arr;
    logic [CH*W-1:0] sh_cmp;
    logic [CH-1:0]   sh_pol;
    logic [CH-1:0]   active;
    logic            sh_center;
    logic            loaded;
    logic            tick;
    logic            up;
    logic [W-1:0]    nxt;
    logic            nxt_dir;

    always_comb begin
        tick    = pcnt == '0;
        up      = !dir && cnt < sh_arr;
        nxt     = !sh_center ? (cnt >= sh_arr ? '0 : cnt + 1'b1)
                : (sh_arr == '0 ? '0 : (up ? cnt + 1'b1 : cnt - 1'b1));
        nxt_dir = nxt == '0 ? 1'b0 : ((sh_center && !up) ? 1'b1 : dir);
        for (int i = 0; i < CH; i++)
            active[i] = cnt < sh_cmp[i*W +: W];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            dir       <= 1'b0;
            pcnt      <= '0;
            sh_arr    <= '0;
            sh_cmp    <= '0;
            sh_pol    <= '0;
            sh_center <= 1'b0;
            loaded    <= 1'b0;
            upd       <= 1'b0;
            cmp_out   <= '0;
        end else if (!en) begin
            cnt     <= '0;
            dir     <= 1'b0;
            pcnt    <= '0;
            loaded  <= 1'b0;
            upd     <= 1'b0;
            cmp_out <= pol;
        end else if (!loaded) begin
            // load clock: capture configuration, arm prescaler, no tick yet
            sh_arr    <= arr;
            sh_cmp    <= cmp;
            sh_pol    <= pol;
            sh_center <= center;
            loaded    <= 1'b1;
            pcnt      <= psc;
            upd       <= 1'b0;
            cmp_out   <= active ^ sh_pol;
        end else begin
            pcnt    <= tick ? psc : pcnt - 1'b1;
            upd     <= tick && nxt == '0;
            cmp_out <= active ^ sh_pol;
            if (tick) begin
                cnt <= nxt;
                dir <= nxt_dir;
                if (nxt == '0) begin
                    sh_arr    <= arr;
                    sh_cmp    <= cmp;
                    sh_pol    <= pol;
                    sh_center <= center;
                end
            end
        end
    end
endmodule

// File: tb/tb_pwm_timer_n.sv
// tb_pwm_timer_n: directed vectors with hand-computed expectations for pwm_timer_n.
module tb_pwm_timer_n;
    localparam int W  = 16;
    localparam int CH = 4;
    localparam int PW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic          center = 1'b0;
    logic [PW-1:0] psc = '0;
    logic [W-1:0]  arr = '0;
    logic [CH*W-1:0] cmp = '0;
    logic [CH-1:0] pol = '0;
    logic [W-1:0]  cnt;
    logic          dir;
    logic          upd;
    logic [CH-1:0] cmp_out;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic          en;
        logic [W-1:0]  cnt;
        logic          upd;
        logic [CH-1:0] out;
    } vec_t;

    vec_t tbl [18];
    int   cseq [8];
    int   pe_cnt [20];
    int   pe_out [20];

    pwm_timer_n #(.W(W), .CH(CH), .PW(PW)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .psc(psc), .arr(arr), .cmp(cmp),
        .pol(pol), .center(center), .cnt(cnt), .dir(dir), .upd(upd), .cmp_out(cmp_out)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic restart();
        en = 1'b0;
        step();
        en = 1'b1;
        step();
    endtask

    initial begin
        // edge PWM, cmp={5,10,0,3}, pol=1000; out depends on previous cnt
        tbl[0]  = '{1'b1, 16'd0, 1'b0, 4'b0000};
        tbl[1]  = '{1'b1, 16'd1, 1'b0, 4'b0101};
        tbl[2]  = '{1'b1, 16'd2, 1'b0, 4'b0101};
        tbl[3]  = '{1'b1, 16'd3, 1'b0, 4'b0101};
        tbl[4]  = '{1'b1, 16'd4, 1'b0, 4'b0100};
        tbl[5]  = '{1'b1, 16'd5, 1'b0, 4'b0100};
        tbl[6]  = '{1'b1, 16'd6, 1'b0, 4'b1100};
        tbl[7]  = '{1'b1, 16'd7, 1'b0, 4'b1100};
        tbl[8]  = '{1'b1, 16'd8, 1'b0, 4'b1100};
        tbl[9]  = '{1'b1, 16'd9, 1'b0, 4'b1100};
        tbl[10] = '{1'b1, 16'd0, 1'b1, 4'b1100};
        tbl[11] = '{1'b1, 16'd1, 1'b0, 4'b0101};
        tbl[12] = '{1'b1, 16'd2, 1'b0, 4'b0101};
        tbl[13] = '{1'b1, 16'd3, 1'b0, 4'b0101};
        tbl[14] = '{1'b1, 16'd4, 1'b0, 4'b0100};
        tbl[15] = '{1'b1, 16'd5, 1'b0, 4'b0100};
        tbl[16] = '{1'b1, 16'd6, 1'b0, 4'b1100};
        tbl[17] = '{1'b0, 16'd0, 1'b0, 4'b1000};
        cseq   = '{0, 1, 2, 3, 4, 3, 2, 1};
        pe_cnt = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2, 3, 4, 0, 1, 2, 3, 4, 3};
        pe_out = '{1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 1, 0, 0, 0};

        step();
        step();
        chk("rst_cnt", cnt, 0);
        chk("rst_upd", upd, 0);
        chk("rst_out", cmp_out, 0);
        chk("rst_dir", dir, 0);

        psc = 0;
        arr = 9;
        cmp = {16'd5, 16'd10, 16'd0, 16'd3};
        pol = 4'b1000;
        rst_n = 1'b1;
        for (int i = 0; i < 18; i++) begin
            en = tbl[i].en;
            step();
            chk($sformatf("tbl%0d_cnt", i), cnt, tbl[i].cnt);
            chk($sformatf("tbl%0d_upd", i), upd, tbl[i].upd);
            chk($sformatf("tbl%0d_out", i), cmp_out, tbl[i].out);
            chk($sformatf("tbl%0d_dir", i), dir, 0);
        end

        arr = 4;
        en = 1'b1;
        step();
        chk("reen_load_cnt", cnt, 0);
        for (int k = 1; k <= 5; k++) begin
            step();
            chk($sformatf("reen%0d_cnt", k), cnt, k % 5);
            chk($sformatf("reen%0d_upd", k), upd, k == 5);
        end
        step();
        step();
        chk("pre_rst_cnt", cnt, 2);
        chk("pre_rst_out", cmp_out, 4'b0101);
        arr = 2;
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_cnt", cnt, 0);
        chk("async_rst_upd", upd, 0);
        chk("async_rst_out", cmp_out, 0);
        #2 rst_n = 1'b1;
        step();
        chk("post_rst_load_cnt", cnt, 0);
        chk("post_rst_load_upd", upd, 0);
        for (int k = 1; k <= 3; k++) begin
            step();
            chk($sformatf("post_rst%0d_cnt", k), cnt, k % 3);
            chk($sformatf("post_rst%0d_upd", k), upd, k == 3);
        end

        psc = 2;
        arr = 4;
        restart();
        chk("psc_load_cnt", cnt, 0);
        for (int k = 1; k <= 16; k++) begin
            step();
            chk($sformatf("psc%0d_cnt", k), cnt, (k / 3) % 5);
            chk($sformatf("psc%0d_upd", k), upd, k == 15);
        end
        psc = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("psc_fast%0d_cnt", k), cnt, k);
        end

        center = 1'b1;
        arr = 4;
        cmp = {16'd0, 16'd0, 16'd0, 16'd2};
        pol = 4'b0000;
        restart();
        for (int k = 1; k <= 16; k++) begin
            step();
            chk($sformatf("ctr%0d_cnt", k), cnt, cseq[k % 8]);
            chk($sformatf("ctr%0d_dir", k), dir, (k % 8) >= 5);
            chk($sformatf("ctr%0d_upd", k), upd, (k % 8) == 0);
            chk($sformatf("ctr%0d_out", k), cmp_out[0], cseq[(k - 1) % 8] < 2);
        end

        center = 1'b0;
        arr = 9;
        cmp = {16'd0, 16'd0, 16'd0, 16'd5};
        restart();
        for (int k = 1; k <= 20; k++) begin
            if (k == 4) begin
                arr = 4;
                cmp = {16'd0, 16'd0, 16'd0, 16'd2};
            end
            if (k == 13) center = 1'b1;
            step();
            chk($sformatf("pre%0d_cnt", k), cnt, pe_cnt[k - 1]);
            chk($sformatf("pre%0d_upd", k), upd, k == 10 || k == 15);
            chk($sformatf("pre%0d_out", k), cmp_out[0], pe_out[k - 1]);
            chk($sformatf("pre%0d_dir", k), dir, k == 20);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
